// File: rtl/menu_ctrl.sv
// Level-select menu: cursor moves with hold-off lockout, ENTER starts a level, clear/ESC returns to menu.
// Optional macro MENU_CURSOR_WRAP_EN makes the cursor wrap at both ends instead of saturating.
module menu_ctrl #(
  parameter int          NUM_ITEMS   = 5,
  parameter int          HOLD_CYCLES = 10_000_000,
  parameter logic [8:0]  KEY_UP      = 9'h01D,
  parameter logic [8:0]  KEY_DOWN    = 9'h01B,
  parameter logic [8:0]  KEY_ENTER   = 9'h05A,
  parameter logic [8:0]  KEY_ESC     = 9'h076
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_make,
  input  logic       clear,
  output logic [2:0] level,
  output logic [2:0] map,
  output logic       start,
  output logic       in_game
);

  localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]     MAP_MAX   = 3'(NUM_ITEMS - 1);

  typedef enum logic {S_MENU, S_PLAY} state_t;

  state_t        r_state;
  logic [2:0]    r_map;
  logic [2:0]    r_level;
  logic          r_start;
  logic          r_in_game;
  logic [HW-1:0] r_hold;

  logic       w_evt;
  logic       w_up;
  logic       w_down;
  logic       w_enter;
  logic       w_esc;
  logic       w_hold_zero;
  logic       w_up_ok;
  logic       w_dn_ok;
  logic [2:0] w_up_nxt;
  logic [2:0] w_dn_nxt;

  assign w_evt       = en & key_valid & key_make;
  assign w_up        = w_evt & (key_code == KEY_UP);
  assign w_down      = w_evt & (key_code == KEY_DOWN);
  assign w_enter     = w_evt & (key_code == KEY_ENTER);
  assign w_esc       = w_evt & (key_code == KEY_ESC);
  assign w_hold_zero = (r_hold == '0);

`ifdef MENU_CURSOR_WRAP_EN
  assign w_up_ok  = 1'b1;
  assign w_dn_ok  = 1'b1;
  assign w_up_nxt = (r_map == 3'd0) ? MAP_MAX : r_map - 3'd1;
  assign w_dn_nxt = (r_map >= MAP_MAX) ? 3'd0 : r_map + 3'd1;
`else
  // A move into the end stop is not a move: it must not start the lockout.
  assign w_up_ok  = (r_map != 3'd0);
  assign w_dn_ok  = (r_map < MAP_MAX);
  assign w_up_nxt = r_map - 3'd1;
  assign w_dn_nxt = r_map + 3'd1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_MENU;
      r_map     <= 3'd0;
      r_level   <= 3'd0;
      r_start   <= 1'b0;
      r_in_game <= 1'b0;
      r_hold    <= '0;
    end else if (en) begin
      r_start <= 1'b0;
      if (!w_hold_zero) r_hold <= r_hold - HW'(1);
      case (r_state)
        S_MENU: begin
          // clear has no meaning here, but it still swallows any key in the same cycle
          if (!clear) begin
            if (w_enter) begin
              r_state   <= S_PLAY;
              r_level   <= r_map + 3'd1;
              r_in_game <= 1'b1;
              r_start   <= 1'b1;
            end else if (w_up && w_hold_zero && w_up_ok) begin
              r_map  <= w_up_nxt;
              r_hold <= HOLD_LOAD;
            end else if (w_down && w_hold_zero && w_dn_ok) begin
              r_map  <= w_dn_nxt;
              r_hold <= HOLD_LOAD;
            end
          end
        end
        S_PLAY: begin
          if (clear || w_esc) begin
            r_state   <= S_MENU;
            r_level   <= 3'd0;
            r_in_game <= 1'b0;
            r_hold    <= '0;
          end
        end
        default: r_state <= S_MENU;
      endcase
    end else begin
      r_start <= 1'b0;
    end
  end

  assign level   = r_level;
  assign map     = r_map;
  assign start   = r_start;
  assign in_game = r_in_game;

endmodule
